// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory byte-stream loader.
package imem_loader_pkg;

   // Width of the frame length field and of the payload byte counter.
   localparam int LEN_W = 16;

   // Loader FSM states. CHECK is reachable only when the checksum option is built in.
   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      CHECK,
      FIN,
      DONE,
      ERROR
   } state_e;

   // Running payload checksum: plain byte-wise XOR accumulation.
   function automatic logic [7:0] csum_acc(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/imem_loader.sv
// Byte-stream program loader: receives a length-prefixed frame, writes the
// payload into byte-addressed instruction memory starting at BASE_ADDR, and
// releases the core from reset once the whole frame has been accepted.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic [7:0]        rx_data_i,
   input  logic              rx_valid_i,
   output logic              rx_ready_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [7:0]        mem_data_o,
   output logic              cpu_rst_o,
   output logic              cpu_en_o,
   output logic              busy_o,
   output logic              error_o
);

   // Largest payload that fits between BASE_ADDR and the top of memory.
   localparam int unsigned MAX_LEN = (2 ** ADDR_W) - BASE_ADDR;

   state_e              state_q, state_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [7:0]          data_q, data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]          csum_q, csum_d;
`endif

   logic             xfer;
   logic [LEN_W-1:0] len_full;

   assign xfer     = rx_valid_i && rx_ready_o;
   assign len_full = {rx_data_i, len_q[7:0]};

   // Status outputs are pure functions of the current state.
   assign rx_ready_o = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                       (state_q == DATA)   || (state_q == CHECK);
   assign busy_o     = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                       (state_q == DATA)   || (state_q == CHECK)  || (state_q == FIN);
   assign cpu_rst_o  = (state_q != DONE);
   assign cpu_en_o   = (state_q == DONE);
   assign error_o    = (state_q == ERROR);
   assign mem_we_o   = we_q;
   assign mem_addr_o = addr_q;
   assign mem_data_o = data_q;

   // State and datapath registers; synchronous reset wins over everything.
   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst_i) begin
         state_q <= IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= ADDR_W'(BASE_ADDR);
         data_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   // Next-state and datapath update; load_i restarts from any state and drops a coincident byte.
   always_comb begin
      // NOTE: every target gets a default first so no latch is inferred.
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      if (load_i) begin
         state_d = LEN_LO;
         cnt_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_d  = '0;
`endif
      end else begin
         case (state_q)
            IDLE: ;
            LEN_LO: begin
               if (xfer) begin
                  len_d[7:0] = rx_data_i;
                  state_d    = LEN_HI;
               end
            end
            LEN_HI: begin
               if (xfer) begin
                  len_d = len_full;
                  if (32'(len_full) > MAX_LEN) begin
                     state_d = ERROR;
                  end else if (len_full == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     state_d = CHECK;
`else
                     state_d = FIN;
`endif
                  end else begin
                     state_d = DATA;
                  end
               end
            end
            DATA: begin
               if (xfer) begin
                  we_d   = 1'b1;
                  data_d = rx_data_i;
                  addr_d = ADDR_W'(32'(BASE_ADDR) + 32'(cnt_q));
                  cnt_d  = cnt_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_d = csum_acc(csum_q, rx_data_i);
`endif
                  if (cnt_q == len_q - 1'b1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     state_d = CHECK;
`else
                     state_d = FIN;
`endif
                  end
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
               if (xfer) begin
                  state_d = (rx_data_i == csum_q) ? FIN : ERROR;
               end
            end
`endif
            FIN:   state_d = DONE;
            DONE:  ;
            ERROR: ;
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (ADDR_W=8, BASE_ADDR=16). Expected
// memory writes are derived from each frame's payload: byte i lands at
// BASE_ADDR+i, visible the cycle after its transfer. Honours
// IMEM_LOADER_CHECKSUM_EN by appending the XOR checksum byte.
module tb_imem_loader;

   localparam int ADDR_W = 8;
   localparam int BASE   = 16;
   localparam int CAP    = (1 << ADDR_W) - BASE;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b1;
   logic              load_i = 1'b0;
   logic [7:0]        rx_data_i = '0;
   logic              rx_valid_i = 1'b0;
   logic              rx_ready_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [7:0]        mem_data_o;
   logic              cpu_rst_o;
   logic              cpu_en_o;
   logic              busy_o;
   logic              error_o;

   imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (load_i),
      .rx_data_i  (rx_data_i),
      .rx_valid_i (rx_valid_i),
      .rx_ready_o (rx_ready_o),
      .mem_we_o   (mem_we_o),
      .mem_addr_o (mem_addr_o),
      .mem_data_o (mem_data_o),
      .cpu_rst_o  (cpu_rst_o),
      .cpu_en_o   (cpu_en_o),
      .busy_o     (busy_o),
      .error_o    (error_o)
   );

   always #5 clk_i = ~clk_i;

   int unsigned cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct packed {
      logic [31:0] cyc;
      logic [7:0]  addr;
      logic [7:0]  data;
   } wr_t;

   wr_t obs_q[$];
   wr_t exp_q[$];

   // Write monitor, sampled mid-cycle.
   always @(negedge clk_i) begin
      if (mem_we_o === 1'b1) obs_q.push_back({32'(cyc), 8'(mem_addr_o), mem_data_o});
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic pulse_load();
      load_i = 1'b1;
      tick();
      load_i = 1'b0;
   endtask

   // Offer one byte until accepted (bounded); t returns the post-transfer cycle.
   task automatic send_byte(input logic [7:0] b, input bit gap, output logic [31:0] t);
      bit ok;
      ok = 1'b0;
      t = '0;
      rx_data_i  = b;
      rx_valid_i = 1'b1;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk_i);
         if (rx_ready_o === 1'b1) begin
            @(posedge clk_i);
            #1;
            t  = cyc;
            ok = 1'b1;
         end
      end
      rx_valid_i = 1'b0;
      if (!ok) check("send_timeout", 32'(ok), 32'd1);
      if (gap) tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 32'(rx_ready_o), 32'd0);
      check({tag, "_we"},    32'(mem_we_o),   32'd0);
      check({tag, "_addr"},  32'(mem_addr_o), 32'(BASE));
      check({tag, "_data"},  32'(mem_data_o), 32'd0);
      check({tag, "_cpurst"},32'(cpu_rst_o),  32'd1);
      check({tag, "_cpuen"}, 32'(cpu_en_o),   32'd0);
      check({tag, "_busy"},  32'(busy_o),     32'd0);
      check({tag, "_err"},   32'(error_o),    32'd0);
   endtask

   task automatic compare_writes(input string tag);
      check({tag, "_nwr"}, 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         check({tag, "_wr_addr"}, 32'(obs_q[i].addr), 32'(exp_q[i].addr));
         check({tag, "_wr_data"}, 32'(obs_q[i].data), 32'(exp_q[i].data));
         check({tag, "_wr_cyc"},  obs_q[i].cyc,       exp_q[i].cyc);
      end
   endtask

   // Send one frame of length len with the given payload and check the outcome.
   task automatic run_frame(input string tag, input bit do_load, input logic [15:0] len,
                            input logic [7:0] pl[$], input bit gaps);
      logic [7:0]  frame[$];
      logic [7:0]  csum;
      logic [31:0] t;
      bit          last;
      obs_q.delete();
      exp_q.delete();
      if (do_load) begin
         pulse_load();
         check({tag, "_ld_err"},   32'(error_o),  32'd0);
         check({tag, "_ld_cpuen"}, 32'(cpu_en_o), 32'd0);
      end
      if (int'(len) > CAP) begin
         send_byte(len[7:0], gaps, t);
         send_byte(len[15:8], 1'b0, t);
         check({tag, "_err"},    32'(error_o),    32'd1);
         check({tag, "_ready"},  32'(rx_ready_o), 32'd0);
         check({tag, "_cpuen"},  32'(cpu_en_o),   32'd0);
         check({tag, "_cpurst"}, 32'(cpu_rst_o),  32'd1);
         check({tag, "_busy"},   32'(busy_o),     32'd0);
         rx_valid_i = 1'b1;
         repeat (3) tick();
         rx_valid_i = 1'b0;
         check({tag, "_err_hold"}, 32'(error_o),      32'd1);
         check({tag, "_nwr"},      32'(obs_q.size()), 32'd0);
         return;
      end
      csum = 8'h00;
      frame.push_back(len[7:0]);
      frame.push_back(len[15:8]);
      foreach (pl[i]) begin
         frame.push_back(pl[i]);
         csum ^= pl[i];
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      frame.push_back(csum);
`endif
      for (int k = 0; k < frame.size(); k++) begin
         last = (k == frame.size() - 1);
         send_byte(frame[k], gaps && !last, t);
         if (k >= 2 && k < 2 + int'(len))
            exp_q.push_back({t, 8'(BASE + k - 2), frame[k]});
      end
      // One FIN cycle, then the core is released.
      check({tag, "_fin_cpurst"}, 32'(cpu_rst_o), 32'd1);
      check({tag, "_fin_cpuen"},  32'(cpu_en_o),  32'd0);
      check({tag, "_fin_busy"},   32'(busy_o),    32'd1);
      tick();
      check({tag, "_done_cpurst"}, 32'(cpu_rst_o),  32'd0);
      check({tag, "_done_cpuen"},  32'(cpu_en_o),   32'd1);
      check({tag, "_done_busy"},   32'(busy_o),     32'd0);
      check({tag, "_done_err"},    32'(error_o),    32'd0);
      check({tag, "_done_ready"},  32'(rx_ready_o), 32'd0);
      compare_writes(tag);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  pl[$];
      logic [31:0] t;
      logic [15:0] rlen;

      // Reset state.
      repeat (3) tick();
      check_reset_outputs("reset");
      rst_i = 1'b0;
      tick();
      check_reset_outputs("idle");

      // addi x1,x0,6 as a 4-byte little-endian word, back-to-back and with gaps.
      pl = '{8'h93, 8'h00, 8'h60, 8'h00};
      run_frame("addi", 1'b1, 16'd4, pl, 1'b0);
      run_frame("addi_gap", 1'b1, 16'd4, pl, 1'b1);

      // Randomized frames.
      for (int f = 0; f < 4; f++) begin
         pl.delete();
         rlen = 16'($urandom_range(1, 24));
         for (int i = 0; i < int'(rlen); i++) pl.push_back(8'($urandom));
         run_frame("rand", 1'b1, rlen, pl, 1'($urandom));
      end

      // Zero-length frame.
      pl.delete();
      run_frame("zero", 1'b1, 16'd0, pl, 1'b0);

      // Oversize length, then a good load recovers.
      run_frame("ovr257", 1'b1, 16'd257, pl, 1'b0);
      pl = '{8'h93, 8'h00, 8'h60, 8'h00};
      run_frame("recover", 1'b1, 16'd4, pl, 1'b0);

      // Boundary: one past capacity fails, exactly capacity fills to the top address.
      pl.delete();
      run_frame("ovr_cap1", 1'b1, 16'(CAP + 1), pl, 1'b0);
      for (int i = 0; i < CAP; i++) pl.push_back(8'($urandom));
      run_frame("full_cap", 1'b1, 16'(CAP), pl, 1'b0);

      // Restart mid-frame; the byte offered together with load_i is dropped.
      obs_q.delete();
      pulse_load();
      send_byte(8'h04, 1'b0, t);
      send_byte(8'h00, 1'b0, t);
      send_byte(8'h11, 1'b0, t);
      send_byte(8'h22, 1'b0, t);
      load_i     = 1'b1;
      rx_valid_i = 1'b1;
      rx_data_i  = 8'h05;
      tick();
      load_i     = 1'b0;
      rx_valid_i = 1'b0;
      check("restart_busy",  32'(busy_o),       32'd1);
      check("restart_ready", 32'(rx_ready_o),   32'd1);
      check("restart_cpuen", 32'(cpu_en_o),     32'd0);
      check("restart_nwr",   32'(obs_q.size()), 32'd2);
      pl = '{8'hAA, 8'hBB};
      run_frame("after_restart", 1'b0, 16'd2, pl, 1'b0);

      // load_i from DONE drops the enable and re-asserts core reset.
      pulse_load();
      check("reload_cpuen",  32'(cpu_en_o),  32'd0);
      check("reload_cpurst", 32'(cpu_rst_o), 32'd1);
      check("reload_busy",   32'(busy_o),    32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Bad checksum: payload written but core stays in reset.
      obs_q.delete();
      send_byte(8'h04, 1'b0, t);
      send_byte(8'h00, 1'b0, t);
      send_byte(8'h93, 1'b0, t);
      send_byte(8'h00, 1'b0, t);
      send_byte(8'h60, 1'b0, t);
      send_byte(8'h00, 1'b0, t);
      send_byte(8'h00, 1'b0, t);
      check("badsum_err",    32'(error_o),      32'd1);
      check("badsum_cpurst", 32'(cpu_rst_o),    32'd1);
      check("badsum_cpuen",  32'(cpu_en_o),     32'd0);
      check("badsum_nwr",    32'(obs_q.size()), 32'd4);
      pulse_load();
`endif

      // Synchronous reset during DATA: back to IDLE, no further writes.
      obs_q.delete();
      send_byte(8'h08, 1'b0, t);
      send_byte(8'h00, 1'b0, t);
      send_byte(8'h01, 1'b0, t);
      send_byte(8'h02, 1'b0, t);
      send_byte(8'h03, 1'b0, t);
      rst_i      = 1'b1;
      load_i     = 1'b1;
      rx_valid_i = 1'b1;
      rx_data_i  = 8'hFF;
      tick();
      load_i = 1'b0;
      check_reset_outputs("rst_data");
      tick();
      rst_i = 1'b0;
      repeat (3) tick();
      rx_valid_i = 1'b0;
      check_reset_outputs("rst_idle");
      check("rst_nwr", 32'(obs_q.size()), 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader that fills the core's byte-addressed instruction memory and then releases the core.
- Frame format on the byte stream: length low byte, length high byte, then payload bytes.
- Payload bytes are written in stream order to consecutive addresses, so a little-endian instruction word is sent LSB first.
- The core is held in reset while loading and enabled when the load completes. This replaces back-door memory preloading in system-level runs.

Parameters:
- ADDR_W, 8, instruction memory address width in bytes; capacity is 2**ADDR_W.
- BASE_ADDR, 0, first byte address written; must be below 2**ADDR_W.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- load_i  in  1  start or restart a load; single-cycle pulse
- rx_data_i  in  8  stream byte
- rx_valid_i  in  1  stream byte valid
- rx_ready_o  out  1  loader can accept a byte
- mem_we_o  out  1  instruction memory byte write enable
- mem_addr_o  out  ADDR_W  write byte address
- mem_data_o  out  8  write byte
- cpu_rst_o  out  1  reset to core
- cpu_en_o  out  1  enable to core
- busy_o  out  1  load in progress
- error_o  out  1  frame error, sticky until load_i or rst_i

Behaviour:
- Reset values: state IDLE; rx_ready_o=0, mem_we_o=0, mem_addr_o=BASE_ADDR, mem_data_o=0, cpu_rst_o=1, cpu_en_o=0, busy_o=0, error_o=0.
- Byte transfer occurs when rx_valid_i && rx_ready_o on a rising edge.
- rx_ready_o=1 only in LEN_LO, LEN_HI, DATA and CHECK. rx_data_i is ignored in every other state.
- States and transitions:
  - IDLE: load_i -> LEN_LO.
  - LEN_LO: on transfer, latch len[7:0] -> LEN_HI.
  - LEN_HI: on transfer, latch len[15:8].
    - If len > 2**ADDR_W - BASE_ADDR -> ERROR.
    - Else if len==0 -> CHECK if the checksum feature is compiled in, otherwise FIN.
    - Else -> DATA.
  - DATA: each transfer registers mem_we_o=1 with mem_data_o=byte and mem_addr_o=BASE_ADDR+count the next cycle; count increments. Write latency is exactly 1 cycle after the transfer. On the transfer of byte len-1 -> CHECK or FIN.
  - FIN: lasts one cycle (the last write is visible here), cpu_rst_o=1 -> DONE.
  - DONE: cpu_rst_o=0, cpu_en_o=1, busy_o=0; holds until load_i.
  - ERROR: error_o=1, cpu_rst_o=1, cpu_en_o=0, rx_ready_o=0; holds until load_i.
- mem_we_o is a single-cycle pulse per byte; it is 0 in all other cycles.
- cpu_rst_o=1 in every state except DONE. cpu_en_o=1 only in DONE.
- busy_o=1 in LEN_LO, LEN_HI, DATA, CHECK and FIN.
- The byte counter is 16 bits. Address arithmetic is truncated to ADDR_W bits; it cannot wrap because of the length check.
- load_i in any state, including mid-frame, DONE or ERROR: next state is LEN_LO, count=0, error_o cleared, cpu_en_o dropped and cpu_rst_o asserted the next cycle.
- A transfer in the same cycle as load_i is discarded.
- Memory contents already written are not cleared on restart.
- rst_i has priority over load_i and any transfer. Mid-load reset returns to IDLE with no further writes.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- With the macro: a trailing byte follows the payload. CHECK accepts one byte and compares it with the XOR of all payload bytes (0x00 for len==0). Equal -> FIN; mismatch -> ERROR. Payload bytes are already written on a mismatch, but the core stays in reset.
- Without the macro: the CHECK state does not exist. The last payload byte goes directly to FIN, and error_o is set only by an oversize length.

Decomposition:
- Package imem_loader_pkg holds:
  - state enum: IDLE, LEN_LO, LEN_HI, DATA, CHECK, FIN, DONE, ERROR;
  - LEN_W=16;
  - a checksum function: byte XOR accumulate.
- No sub-module; a single FSM with datapath registers.

Test Plan:
- Load 04 00 93 00 60 00 (addi x1,x0,6) -> writes 0x93@0, 0x00@1, 0x60@2, 0x00@3, one per accepted byte at 1-cycle latency. Then one FIN cycle, cpu_rst_o 1->0 and cpu_en_o=1. Core run leaves x1=6.
- Same frame with rx_valid_i toggled every other cycle and BASE_ADDR=16 -> addresses 16..19, identical data, no extra or duplicate writes.
- Frame 00 00 -> no mem_we_o; DONE reached 2 cycles after the LEN_HI transfer. With the checksum feature, the trailing byte 00 is required first.
- ADDR_W=8 with length 01 01 (257) -> ERROR, error_o=1, rx_ready_o=0, cpu_en_o stays 0. Then load_i plus a valid frame -> error_o clears and the load succeeds.
- load_i after 2 payload bytes of a 4-byte frame -> LEN_LO the next cycle, count restarts at 0, cpu_en_o=0. rst_i during DATA -> IDLE with all outputs at their reset values.
- With IMEM_LOADER_CHECKSUM_EN: payload 93 00 60 00 plus checksum F3 -> DONE. Checksum 00 -> ERROR, error_o=1, cpu_rst_o stays 1.
